// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle shared by the hazard unit
// and the pipeline datapath that drives it.
interface pipeline_hazard_unit_if #(
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 16
);
    logic                   id_valid;
    logic [REG_W-1:0]       id_rs;
    logic [REG_W-1:0]       id_rt;
    logic                   id_use_rs;
    logic                   id_use_rt;
    logic [REG_W-1:0]       id_dest;
    logic                   id_regwrite;
    logic                   id_memread;
    logic                   redirect;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic                   stall;
    logic                   bubble;
    logic [FLUSH_DEPTH-1:0] flush_mask;
    logic [CNT_W-1:0]       stall_count;
    logic [CNT_W-1:0]       flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, redirect,
        input  fwd_a, fwd_b, stall, bubble, flush_mask, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest,
               id_regwrite, id_memread, redirect,
        output fwd_a, fwd_b, stall, bubble, flush_mask, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: tracks EX/MEM/WB producers and resolves
// operand forwarding, load-use stalls and redirect flushes with zero latency.
module pipeline_hazard_unit #(
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 3,
    parameter int FWD_WB      = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dest;
    } stage_t;

    localparam stage_t           STAGE_CLR = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, dest: {REG_W{1'b0}}};
    localparam logic             WB_EN     = (FWD_WB != 32'sd0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Register $0 is hardwired, so writes to it never create a dependency.
    function automatic logic is_producer(stage_t e);
        return e.valid & e.regwrite & (e.dest != {REG_W{1'b0}});
    endfunction

    function automatic logic [1:0] fwd_select(logic ex_valid, logic use_src, logic [REG_W-1:0] src,
                                              stage_t mem, stage_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_valid && use_src && is_producer(mem) && (mem.dest == src)) begin
            sel = 2'b10;
        end else if (WB_EN && ex_valid && use_src && is_producer(wb) && (wb.dest == src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    stage_t                 ex_r;
    stage_t                 mem_r;
    stage_t                 wb_r;
    stage_t                 ex_next_s;
    stage_t                 mem_next_s;
    logic [REG_W-1:0]       ex_rs_r;
    logic [REG_W-1:0]       ex_rt_r;
    logic                   ex_use_rs_r;
    logic                   ex_use_rt_r;
    logic                   load_use_s;
    logic                   stall_s;
    logic [1:0]             fwd_a_s;
    logic [1:0]             fwd_b_s;
    logic [FLUSH_DEPTH-1:0] flush_mask_s;
    logic [CNT_W-1:0]       stall_count_r;
    logic [CNT_W-1:0]       flush_count_r;

    // Hazard decode: forwarding selects, load-use detection and redirect priority.
    always_comb begin
        fwd_a_s      = fwd_select(ex_r.valid, ex_use_rs_r, ex_rs_r, mem_r, wb_r);
        fwd_b_s      = fwd_select(ex_r.valid, ex_use_rt_r, ex_rt_r, mem_r, wb_r);
        load_use_s   = 1'b0;
        stall_s      = 1'b0;
        flush_mask_s = {FLUSH_DEPTH{1'b0}};
        if (bus.id_valid && is_producer(ex_r) && ex_r.memread) begin
            load_use_s = (bus.id_use_rs && (ex_r.dest == bus.id_rs)) ||
                         (bus.id_use_rt && (ex_r.dest == bus.id_rt));
        end else begin
            load_use_s = 1'b0;
        end
        // A taken redirect kills the stalled instruction anyway, so it wins.
        if (bus.redirect) begin
            stall_s      = 1'b0;
            flush_mask_s = {FLUSH_DEPTH{1'b1}};
        end else begin
            stall_s      = load_use_s;
            flush_mask_s = {FLUSH_DEPTH{1'b0}};
        end
    end

    // Scoreboard next state: bubbles on stall, squashes EX and MEM on redirect.
    always_comb begin
        ex_next_s          = STAGE_CLR;
        ex_next_s.valid    = bus.id_valid & ~stall_s & ~bus.redirect;
        ex_next_s.regwrite = bus.id_regwrite;
        ex_next_s.memread  = bus.id_memread;
        ex_next_s.dest     = bus.id_dest;
        mem_next_s         = ex_r;
        mem_next_s.valid   = ex_r.valid & ~bus.redirect;
    end

    // Scoreboard shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r        <= STAGE_CLR;
            mem_r       <= STAGE_CLR;
            wb_r        <= STAGE_CLR;
            ex_rs_r     <= {REG_W{1'b0}};
            ex_rt_r     <= {REG_W{1'b0}};
            ex_use_rs_r <= 1'b0;
            ex_use_rt_r <= 1'b0;
        end else begin
            ex_r        <= ex_next_s;
            mem_r       <= mem_next_s;
            wb_r        <= mem_r;
            ex_rs_r     <= bus.id_rs;
            ex_rt_r     <= bus.id_rt;
            ex_use_rs_r <= bus.id_use_rs & bus.id_valid;
            ex_use_rt_r <= bus.id_use_rt & bus.id_valid;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
            flush_count_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end
            if (bus.redirect && (flush_count_r != CNT_MAX)) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end
        end
    end

    assign bus.fwd_a       = fwd_a_s;
    assign bus.fwd_b       = fwd_b_s;
    assign bus.stall       = stall_s;
    assign bus.bubble      = stall_s;
    assign bus.flush_mask  = flush_mask_s;
    assign bus.stall_count = stall_count_r;
    assign bus.flush_count = flush_count_r;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed vector table, randomized
// run against a pipeline-list reference model, and reset/saturation sequences.
module tb_pipeline_hazard_unit;
    localparam int REG_W  = 5;
    localparam int FD     = 3;
    localparam int FWD_WB = 1;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.REG_W(REG_W), .FLUSH_DEPTH(FD), .CNT_W(CNT_W)) hif ();

    pipeline_hazard_unit #(.REG_W(REG_W), .FLUSH_DEPTH(FD), .FWD_WB(FWD_WB), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; int dest; bit rw; bit mr; bit redir;
        int fa; int fb; bit st; bit fl; int sc; int fc;
    } vec_t;

    typedef struct { bit v; bit rw; bit mr; bit urs; bit urt; int dest; int rs; int rt; } ent_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[16];
    vec_t cur;
    ent_t pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
    int   m_sc;
    int   m_fc;

    function automatic vec_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr,
                                bit redir, int fa, int fb, bit st, bit fl, int sc, int fc);
        vec_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.dest = dest; x.rw = rw;
        x.mr = mr; x.redir = redir; x.fa = fa; x.fb = fb; x.st = st; x.fl = fl; x.sc = sc; x.fc = fc;
        return x;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t x);
        cur             = x;
        hif.id_valid    = x.v;
        hif.id_rs       = x.rs[REG_W-1:0];
        hif.id_rt       = x.rt[REG_W-1:0];
        hif.id_use_rs   = x.urs;
        hif.id_use_rt   = x.urt;
        hif.id_dest     = x.dest[REG_W-1:0];
        hif.id_regwrite = x.rw;
        hif.id_memread  = x.mr;
        hif.redirect    = x.redir;
    endtask

    // Reference model: the youngest valid writer of a register supplies it.
    function automatic bit prod(ent_t e);
        return e.v && e.rw && (e.dest != 0);
    endfunction

    function automatic int m_fwd(int src, bit u);
        if (!pipe[0].v || !u) return 0;
        if (prod(pipe[1]) && pipe[1].dest == src) return 2;
        if (FWD_WB != 0 && prod(pipe[2]) && pipe[2].dest == src) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic check_all(string tag, output bit est);
        bit lu;
        lu  = cur.v && prod(pipe[0]) && pipe[0].mr &&
              ((cur.urs && pipe[0].dest == cur.rs) || (cur.urt && pipe[0].dest == cur.rt));
        est = lu && !cur.redir;
        check({tag, ".fwd_a"}, int'(hif.fwd_a), m_fwd(pipe[0].rs, pipe[0].urs));
        check({tag, ".fwd_b"}, int'(hif.fwd_b), m_fwd(pipe[0].rt, pipe[0].urt));
        check({tag, ".stall"}, int'(hif.stall), int'(est));
        check({tag, ".bubble"}, int'(hif.bubble), int'(est));
        check({tag, ".flush"}, int'(hif.flush_mask), cur.redir ? (1 << FD) - 1 : 0);
        check({tag, ".stall_count"}, int'(hif.stall_count), m_sc);
        check({tag, ".flush_count"}, int'(hif.flush_count), m_fc);
    endtask

    task automatic advance(bit est);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (cur.redir) pipe[1].v = 1'b0;
        pipe[0] = '{v: cur.v && !est && !cur.redir, rw: cur.rw, mr: cur.mr, urs: cur.urs,
                    urt: cur.urt, dest: cur.dest, rs: cur.rs, rt: cur.rt};
        if (est && m_sc < CNT_MAX) m_sc++;
        if (cur.redir && m_fc < CNT_MAX) m_fc++;
    endtask

    initial begin
        bit   est;
        vec_t nop;
        vec_t r;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(nop);

        //            v rs rt urs urt dst rw mr rd | fa fb st fl sc fc
        vecs[0]  = mk(1, 1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 3, 4, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 3, 3, 1, 1,  8, 1, 0, 0,  2, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  3, 3, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 5, 5, 1, 1,  6, 1, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(1, 5, 5, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  3, 3, 0, 0, 1, 0);
        vecs[8]  = mk(1, 1, 0, 1, 0,  0, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        vecs[9]  = mk(1, 0, 0, 1, 1,  9, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        vecs[10] = mk(1, 1, 0, 1, 0,  0, 1, 1, 0,  0, 0, 0, 0, 1, 0);
        vecs[11] = mk(1, 0, 0, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        vecs[12] = mk(1, 2, 0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0, 1, 0);
        vecs[13] = mk(1, 5, 0, 1, 0, 11, 1, 0, 1,  0, 0, 0, 1, 1, 0);
        vecs[14] = mk(1, 5, 5, 1, 1, 12, 1, 0, 0,  0, 0, 0, 0, 1, 1);
        vecs[15] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 1);

        // Reset state while held low.
        #12;
        check("rst.fwd_a", int'(hif.fwd_a), 0);
        check("rst.stall", int'(hif.stall), 0);
        check("rst.flush", int'(hif.flush_mask), 0);
        check("rst.stall_count", int'(hif.stall_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d.fwd_a", i), int'(hif.fwd_a), vecs[i].fa);
            check($sformatf("vec%0d.fwd_b", i), int'(hif.fwd_b), vecs[i].fb);
            check($sformatf("vec%0d.stall", i), int'(hif.stall), int'(vecs[i].st));
            check($sformatf("vec%0d.bubble", i), int'(hif.bubble), int'(vecs[i].st));
            check($sformatf("vec%0d.flush", i), int'(hif.flush_mask), vecs[i].fl ? 7 : 0);
            check($sformatf("vec%0d.stall_count", i), int'(hif.stall_count), vecs[i].sc);
            check($sformatf("vec%0d.flush_count", i), int'(hif.flush_count), vecs[i].fc);
        end

        // Randomized chunks against the model, each started by a mid-cycle reset.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(nop);
            reset = 1'b0;
            #1;
            model_reset();
            check_all($sformatf("rnd_rst%0d", c), est);
            reset = 1'b1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                r = nop;
                r.v     = ($urandom_range(0, 3) != 0);
                r.rs    = $urandom_range(0, 3);
                r.rt    = $urandom_range(0, 3);
                r.urs   = $urandom_range(0, 1);
                r.urt   = $urandom_range(0, 1);
                r.dest  = $urandom_range(0, 3);
                r.rw    = ($urandom_range(0, 4) != 0);
                r.mr    = $urandom_range(0, 1);
                r.redir = ($urandom_range(0, 7) == 0);
                drive(r);
                #1;
                check_all($sformatf("rnd%0d_%0d", c, n), est);
                @(posedge clk);
                advance(est);
            end
        end

        // Asynchronous reset between edges clears outputs and counters at once.
        @(negedge clk);
        drive(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #2;
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1;
        check("async.stall", int'(hif.stall), 0);
        check("async.fwd_b", int'(hif.fwd_b), 0);
        check("async.stall_count", int'(hif.stall_count), 0);
        check("async.flush_count", int'(hif.flush_count), 0);

        // First edge after release loads EX from the ID inputs.
        @(negedge clk);
        drive(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b1;
        @(negedge clk);
        drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("release.stall", int'(hif.stall), 1);

        // 2^CNT_W+3 load-use stalls: lw $5,($5) back to back stalls every other cycle.
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 2 * ((1 << CNT_W) + 3); i++) begin
            @(negedge clk);
            drive(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
            #1;
            check($sformatf("sat_st%0d.stall", i), int'(hif.stall), i % 2);
            check($sformatf("sat_st%0d.count", i), int'(hif.stall_count),
                  (i / 2 < CNT_MAX) ? i / 2 : CNT_MAX);
        end
        @(negedge clk);
        drive(nop);
        #1;
        check("sat_st.final", int'(hif.stall_count), CNT_MAX);

        // Redirect counter saturation.
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            @(negedge clk);
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            #1;
            check($sformatf("sat_fl%0d.count", i), int'(hif.flush_count), (i < CNT_MAX) ? i : CNT_MAX);
        end
        @(negedge clk);
        drive(nop);
        #1;
        check("sat_fl.final", int'(hif.flush_count), CNT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 SHALL provide parameter REG_W, default 5, register-address width.
REQ-002 SHALL provide parameter FLUSH_DEPTH, default 3, number of stage registers younger than the redirecting stage (IF/ID, ID/EX, EX/MEM); legal range 1..4.
REQ-003 SHALL provide parameter FWD_WB, default 1, enabling forwarding from the WB stage (0 = MEM-only forwarding).
REQ-004 SHALL provide parameter CNT_W, default 16, performance-counter width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_rs, id_rt  in  REG_W each  source registers of the ID instruction.
REQ-009 id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-010 id_dest  in  REG_W  destination register of the ID instruction (after RegDst/JAL selection).
REQ-011 id_regwrite, id_memread  in  1 each  ID instruction writes a register / is a load.
REQ-012 redirect  in  1  branch, jump or JR taken, resolved in MEM this cycle.
REQ-013 fwd_a, fwd_b  out  2 each  ALU operand selects for the EX instruction: 00 register file, 10 MEM result, 11 WB result.
REQ-014 stall  out  1  hold PC and IF/ID this cycle.
REQ-015 bubble  out  1  load NOP controls into ID/EX this cycle.
REQ-016 flush_mask  out  FLUSH_DEPTH  bit k clears stage register k (0 = IF/ID) this cycle.
REQ-017 stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-018 SHALL keep an internal scoreboard of three entries (EX, MEM, WB), each holding {valid, dest, regwrite, memread}; EX also holds {rs, rt, use_rs, use_rt}.
REQ-019 Each clock edge, SHALL shift WB<=MEM, MEM<=EX, and EX<=ID fields qualified by id_valid.
REQ-020 SHALL treat an entry as a forwarding/hazard producer only when valid=1, regwrite=1 and dest!=0.
REQ-021 fwd_a SHALL be 10 when the MEM producer dest equals EX rs with use_rs=1; else 11 when FWD_WB=1 and the WB producer matches; else 00; fwd_b identically for rt.
REQ-022 A match in both MEM and WB SHALL select MEM (youngest data wins).
REQ-023 Load-use: stall and bubble SHALL both be 1 in the cycle where id_valid=1, the EX producer has memread=1, and its dest matches id_rs (id_use_rs=1) or id_rt (id_use_rt=1).
REQ-024 On a stall, the EX entry SHALL load valid=0 while MEM and WB shift normally; the ID instruction re-presents next cycle and sees no hazard, giving exactly one bubble per load-use.
REQ-025 redirect=1 SHALL drive flush_mask to all ones and force stall=0 and bubble=0 in that cycle, even if a load-use condition is present.
REQ-026 On redirect, the EX entry SHALL load valid=0 and the MEM entry SHALL load valid=0 (the flushed EX-stage instruction); WB SHALL take the redirecting instruction unchanged.
REQ-027 fwd_a, fwd_b, stall, bubble and flush_mask SHALL be combinational from the scoreboard and current inputs (zero-cycle latency); the scoreboard SHALL be the only state besides the counters.
REQ-028 stall_count SHALL increment on each cycle with stall=1; flush_count on each cycle with redirect=1; both SHALL hold at all ones instead of wrapping.
REQ-029 id_valid=0 SHALL suppress the load-use stall regardless of other ID inputs.

Reset
REQ-030 While reset=0, all scoreboard valid bits and both counters SHALL be 0, giving fwd_a=fwd_b=00, stall=bubble=0 and flush_mask=0 (absent redirect).
REQ-031 Reset assertion mid-operation SHALL clear state immediately without waiting for clk; the first edge after release SHALL load the EX entry from the ID inputs.

Verification
REQ-032 add $3 in ID, then sub reading $3 in the next cycle -> in the sub's EX cycle fwd_a=10; one cycle later an instruction reading $3 gets fwd=11.
REQ-033 lw $5 then add $6,$5,$5 -> stall=bubble=1 for exactly one cycle, stall_count=1, then fwd_a=fwd_b=11 in add's EX cycle (FWD_WB=1).
REQ-034 A producer writing $0 followed by a reader of $0 -> fwd=00 and no stall.
REQ-035 A load-use condition coincident with redirect=1 -> flush_mask=111, stall=0, flush_count=1; the next cycle shows no forwarding from the flushed entries.
REQ-036 2^CNT_W+3 consecutive stall cycles -> stall_count saturates at all ones.
REQ-037 reset pulled low between clock edges -> outputs return to their reset values immediately; counters read 0.
